// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between a data port (D)
// and an instruction-fetch port (I), with a per-access timeout.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_enable,
  input  logic              d_write_read,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  input  logic              i_enable,
  input  logic              i_write_read,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  output logic              mem_enable,
  output logic              mem_write_read,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CTRL_W-1:0] mem_ctrl,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic             PORT_D   = 1'b0;
  localparam logic             PORT_I   = 1'b1;
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             gnt_q;
  logic             last_gnt_q;
  logic             issue_q;
  logic             pend_d_q;
  logic             pend_i_q;
  logic [CNT_W-1:0] cnt_q;

  logic req_d, req_i, in_busy, tmo, finish, grant_sel, gnt_is_d, gnt_is_i;

  assign req_d     = pend_d_q | d_enable;
  assign req_i     = pend_i_q | i_enable;
  assign in_busy   = (state_q == BUSY);
  assign tmo       = in_busy & ~mem_done & TMO_EN & (cnt_q == TMO_LAST);
  assign finish    = in_busy & (mem_done | tmo);
  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign grant_sel = (req_d & req_i) ? ~last_gnt_q : req_i;
  assign gnt_is_d  = in_busy & (gnt_q == PORT_D);
  assign gnt_is_i  = in_busy & (gnt_q == PORT_I);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_D;
      last_gnt_q <= PORT_I;
      issue_q    <= 1'b0;
      pend_d_q   <= 1'b0;
      pend_i_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d | req_i) begin
            state_q  <= BUSY;
            gnt_q    <= grant_sel;
            issue_q  <= 1'b1;
            cnt_q    <= '0;
            // The granted request is now carried by gnt_q; the loser stays pending.
            pend_d_q <= req_d & (grant_sel != PORT_D);
            pend_i_q <= req_i & (grant_sel != PORT_I);
          end
        end
        BUSY: begin
          issue_q <= 1'b0;
          if (gnt_q == PORT_D) pend_i_q <= pend_i_q | i_enable;
          else                 pend_d_q <= pend_d_q | d_enable;
          if (finish) begin
            state_q    <= IDLE;
            last_gnt_q <= gnt_q;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_write_read = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_ctrl       = '0;
    if (gnt_is_d) begin
      mem_write_read = d_write_read;
      mem_addr       = d_addr;
      mem_wdata      = d_wdata;
      mem_ctrl       = d_ctrl;
    end else if (gnt_is_i) begin
      mem_write_read = i_write_read;
      mem_addr       = i_addr;
      mem_wdata      = i_wdata;
      mem_ctrl       = i_ctrl;
    end
  end

  assign mem_enable = in_busy & issue_q;
  assign busy       = in_busy;

  assign d_done  = finish & gnt_is_d;
  assign d_err   = tmo & gnt_is_d;
  assign d_rdata = (gnt_is_d & mem_done) ? mem_rdata : '0;
  assign i_done  = finish & gnt_is_i;
  assign i_err   = tmo & gnt_is_i;
  assign i_rdata = (gnt_is_i & mem_done) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default-timeout instance plus a TIMEOUT=4
// instance sharing the same stimulus.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_enable, d_write_read, i_enable, i_write_read, mem_done;
  logic [DW-1:0] d_addr, d_wdata, i_addr, i_wdata, mem_rdata;
  logic [CW-1:0] d_ctrl, i_ctrl;

  logic [DW-1:0] d_rdata, i_rdata, mem_addr, mem_wdata;
  logic [CW-1:0] mem_ctrl;
  logic          d_done, d_err, i_done, i_err, mem_enable, mem_write_read, busy;

  logic [DW-1:0] t_d_rdata, t_i_rdata, t_mem_addr, t_mem_wdata;
  logic [CW-1:0] t_mem_ctrl;
  logic          t_d_done, t_d_err, t_i_done, t_i_err, t_mem_enable, t_mem_write_read, t_busy;

  // {busy, mem_enable, d_done, d_err, i_done, i_err}
  logic [5:0] flags, t_flags;
  assign flags   = {busy, mem_enable, d_done, d_err, i_done, i_err};
  assign t_flags = {t_busy, t_mem_enable, t_d_done, t_d_err, t_i_done, t_i_err};

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .CTRL_W(CW), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .d_enable(d_enable), .d_write_read(d_write_read), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ctrl(d_ctrl), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .i_enable(i_enable), .i_write_read(i_write_read), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ctrl(i_ctrl), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .mem_enable(mem_enable), .mem_write_read(mem_write_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy)
  );

  mem_port_arbiter #(.DATA_W(DW), .CTRL_W(CW), .TIMEOUT(4), .CNT_W(8)) dut_t (
    .clk(clk), .reset(reset),
    .d_enable(d_enable), .d_write_read(d_write_read), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ctrl(d_ctrl), .d_rdata(t_d_rdata), .d_done(t_d_done), .d_err(t_d_err),
    .i_enable(i_enable), .i_write_read(i_write_read), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ctrl(i_ctrl), .i_rdata(t_i_rdata), .i_done(t_i_done), .i_err(t_i_err),
    .mem_enable(t_mem_enable), .mem_write_read(t_mem_write_read), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ctrl(t_mem_ctrl), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_enable = 1'b0; d_write_read = 1'b0; d_addr = '0; d_wdata = '0; d_ctrl = '0;
    i_enable = 1'b0; i_write_read = 1'b0; i_addr = '0; i_wdata = '0; i_ctrl = '0;
    mem_done = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    d_enable = 1'b1; i_enable = 1'b1; mem_done = 1'b1; mem_rdata = 32'h1234_5678;
    d_addr = 32'h10; i_addr = 32'h20;
    tick();
    tick();
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", flags, 6'b000000); end
    n_cmp++; if ({mem_addr, d_rdata, i_rdata} !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, d_rdata, i_rdata); end
    n_cmp++; if (t_flags !== 6'b000000) begin n_fail++; $display("FAIL reset_flags_t got=%b exp=%b", t_flags, 6'b000000); end
    do_reset();
  endtask

  task automatic test_d_load();
    do_reset();
    d_enable = 1'b1; d_addr = 32'h100; d_ctrl = 3'b010;
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t1_req_cycle got=%b exp=%b", flags, 6'b000000); end
    tick();
    d_enable = 1'b0; mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (flags !== 6'b111000) begin n_fail++; $display("FAIL t1_issue_flags got=%b exp=%b", flags, 6'b111000); end
    n_cmp++; if (mem_addr !== 32'h100 || mem_ctrl !== 3'b010 || mem_write_read !== 1'b0) begin n_fail++; $display("FAIL t1_mem_bus got=%h/%b/%b exp=100/010/0", mem_addr, mem_ctrl, mem_write_read); end
    n_cmp++; if (d_rdata !== 32'hDEAD_BEEF || i_rdata !== '0) begin n_fail++; $display("FAIL t1_rdata got=%h/%h exp=deadbeef/0", d_rdata, i_rdata); end
    tick();
    mem_done = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b000000 || mem_addr !== '0) begin n_fail++; $display("FAIL t1_back_idle got=%b/%h exp=000000/0", flags, mem_addr); end
  endtask

  task automatic test_tie();
    do_reset();
    d_enable = 1'b1; d_addr = 32'h200;
    i_enable = 1'b1; i_addr = 32'h300; i_write_read = 1'b1; i_wdata = 32'hCAFE; i_ctrl = 3'b101;
    tick();
    d_enable = 1'b0; i_enable = 1'b0; mem_done = 1'b1; mem_rdata = 32'h11;
    #1;
    n_cmp++; if (flags !== 6'b111000 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL t2_tie1_d got=%b/%h exp=111000/200", flags, mem_addr); end
    tick();
    mem_done = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t2_gap got=%b exp=%b", flags, 6'b000000); end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h22;
    #1;
    n_cmp++; if (flags !== 6'b110010 || i_rdata !== 32'h22) begin n_fail++; $display("FAIL t2_i_issue got=%b/%h exp=110010/22", flags, i_rdata); end
    n_cmp++; if (mem_addr !== 32'h300 || mem_wdata !== 32'hCAFE || mem_ctrl !== 3'b101 || mem_write_read !== 1'b1) begin n_fail++; $display("FAIL t2_i_bus got=%h/%h/%b/%b exp=300/cafe/101/1", mem_addr, mem_wdata, mem_ctrl, mem_write_read); end
    tick();
    mem_done = 1'b0; d_enable = 1'b1;
    tick();
    d_enable = 1'b0; mem_done = 1'b1;
    #1;
    n_cmp++; if (flags !== 6'b111000) begin n_fail++; $display("FAIL t2_d_only got=%b exp=%b", flags, 6'b111000); end
    tick();
    mem_done = 1'b0; d_enable = 1'b1; i_enable = 1'b1;
    tick();
    d_enable = 1'b0; i_enable = 1'b0; mem_done = 1'b1;
    #1;
    n_cmp++; if (flags !== 6'b110010 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL t2_tie2_i got=%b/%h exp=110010/300", flags, mem_addr); end
    tick();
    mem_done = 1'b0;
    tick();
    mem_done = 1'b1;
    #1;
    n_cmp++; if (flags !== 6'b111000 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL t2_tie2_d_next got=%b/%h exp=111000/200", flags, mem_addr); end
    tick();
    mem_done = 1'b0;
  endtask

  task automatic test_drop_enable();
    int done_cnt = 0;
    do_reset();
    d_enable = 1'b1; d_addr = 32'h400;
    tick();
    d_enable = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b110000 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL t3_issue got=%b/%h exp=110000/400", flags, mem_addr); end
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      if (d_done === 1'b1) done_cnt++;
      n_cmp++; if (flags !== 6'b100000 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL t3_wait%0d got=%b/%h exp=100000/400", c, flags, mem_addr); end
    end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h55;
    #1;
    if (d_done === 1'b1) done_cnt++;
    n_cmp++; if (d_rdata !== 32'h55 || d_err !== 1'b0) begin n_fail++; $display("FAIL t3_rdata got=%h/%b exp=55/0", d_rdata, d_err); end
    tick();
    mem_done = 1'b0;
    #1;
    if (d_done === 1'b1) done_cnt++;
    tick();
    #1;
    if (d_done === 1'b1) done_cnt++;
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL t3_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t3_no_reissue got=%b exp=%b", flags, 6'b000000); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_enable = 1'b1; i_write_read = 1'b1; i_addr = 32'h500; i_wdata = 32'hABCD;
    tick();
    i_enable = 1'b0;
    #1;
    n_cmp++; if (t_flags !== 6'b110000) begin n_fail++; $display("FAIL t4_issue got=%b exp=%b", t_flags, 6'b110000); end
    tick();
    tick();
    #1;
    n_cmp++; if (t_flags !== 6'b100000) begin n_fail++; $display("FAIL t4_third_cycle got=%b exp=%b", t_flags, 6'b100000); end
    tick();
    #1;
    n_cmp++; if (t_flags !== 6'b100011 || t_i_rdata !== '0) begin n_fail++; $display("FAIL t4_timeout got=%b/%h exp=100011/0", t_flags, t_i_rdata); end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h77;
    #1;
    n_cmp++; if (t_flags !== 6'b000000 || t_i_rdata !== '0) begin n_fail++; $display("FAIL t4_stray_done got=%b/%h exp=000000/0", t_flags, t_i_rdata); end
    tick();
    mem_done = 1'b0;
    #1;
    n_cmp++; if (t_flags !== 6'b000000) begin n_fail++; $display("FAIL t4_stays_idle got=%b exp=%b", t_flags, 6'b000000); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    d_enable = 1'b1; d_addr = 32'h600;
    tick();
    mem_done = 1'b1; mem_rdata = 32'h66;
    i_enable = 1'b1; i_addr = 32'h700;
    #1;
    n_cmp++; if (flags !== 6'b111000 || d_rdata !== 32'h66) begin n_fail++; $display("FAIL t5_d_done got=%b/%h exp=111000/66", flags, d_rdata); end
    tick();
    d_enable = 1'b0; i_enable = 1'b0; mem_done = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t5_gap got=%b exp=%b", flags, 6'b000000); end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h77;
    #1;
    n_cmp++; if (flags !== 6'b110010 || mem_addr !== 32'h700) begin n_fail++; $display("FAIL t5_i_issue got=%b/%h exp=110010/700", flags, mem_addr); end
    tick();
    mem_done = 1'b0;
    tick();
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t5_d_not_reissued got=%b exp=%b", flags, 6'b000000); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    d_enable = 1'b1; d_addr = 32'h800;
    i_enable = 1'b1; i_addr = 32'h900;
    tick();
    d_enable = 1'b0; i_enable = 1'b0; mem_done = 1'b1; mem_rdata = 32'hAA;
    #1;
    n_cmp++; if (flags !== 6'b111000) begin n_fail++; $display("FAIL t6_before got=%b exp=%b", flags, 6'b111000); end
    reset = 1'b1;
    #1;
    n_cmp++; if (flags !== 6'b000000 || mem_addr !== '0 || d_rdata !== '0) begin n_fail++; $display("FAIL t6_async got=%b/%h/%h exp=000000/0/0", flags, mem_addr, d_rdata); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t6_stray_done got=%b exp=%b", flags, 6'b000000); end
    tick();
    mem_done = 1'b0;
    #1;
    n_cmp++; if (flags !== 6'b000000) begin n_fail++; $display("FAIL t6_pend_cleared got=%b exp=%b", flags, 6'b000000); end
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0; mem_done = 1'b1; mem_rdata = 32'h99;
    #1;
    n_cmp++; if (flags !== 6'b110010 || mem_addr !== 32'h900 || i_rdata !== 32'h99) begin n_fail++; $display("FAIL t6_next_req got=%b/%h/%h exp=110010/900/99", flags, mem_addr, i_rdata); end
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_d_load();
    test_tie();
    test_drop_enable();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
